// File: rtl/microwave_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : microwave_ctrl
//  Description : Microwave oven controller. One-hot FSM (CLOSED, OPEN, COOK,
//                PAUSE, BELL) with a tick-driven cook-time countdown, a PWM
//                power modulator of period 2^PWR_W-1 cycles and a timed bell.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    TIME_W    width of the cook-time counter (ticks)
//    PWR_W     width of the power level; PWM period P = 2^PWR_W-1 cycles
//    BELL_CYC  bell duration in clk cycles (>= 1)
//  Ports
//    clk        in   rising-edge clock
//    nrst       in   asynchronous active-low reset
//    door       in   1 = door open
//    start      in   start / resume request
//    cancel     in   abort the current cook
//    tick       in   one-cycle time-base strobe
//    time_in    in   cook time, latched on start from CLOSED
//    power_in   in   power level 0..P, latched on start from CLOSED
//    lock       in   child lock (only with MICROWAVE_CHILD_LOCK_EN)
//    heat       out  magnetron enable
//    light      out  cavity lamp
//    bell       out  end-of-cook signal
//    remaining  out  ticks left
//    busy       out  cook in progress or paused
//  Build option
//    MICROWAVE_CHILD_LOCK_EN  adds the lock input; lock=1 blocks start in
//                             CLOSED and PAUSE, cancel is still honoured.
// ============================================================================
module microwave_ctrl #(
   parameter int TIME_W   = 8,
   parameter int PWR_W    = 3,
   parameter int BELL_CYC = 4
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              door,
   input  logic              start,
   input  logic              cancel,
   input  logic              tick,
   input  logic [TIME_W-1:0] time_in,
   input  logic [PWR_W-1:0]  power_in,
`ifdef MICROWAVE_CHILD_LOCK_EN
   input  logic              lock,
`endif
   output logic              heat,
   output logic              light,
   output logic              bell,
   output logic [TIME_W-1:0] remaining,
   output logic              busy
);

   localparam int I_CLOSED = 0;
   localparam int I_OPEN   = 1;
   localparam int I_COOK   = 2;
   localparam int I_PAUSE  = 3;
   localparam int I_BELL   = 4;

   localparam logic [4:0] S_CLOSED = 5'b00001;
   localparam logic [4:0] S_OPEN   = 5'b00010;
   localparam logic [4:0] S_COOK   = 5'b00100;
   localparam logic [4:0] S_PAUSE  = 5'b01000;
   localparam logic [4:0] S_BELL   = 5'b10000;

   localparam int                 P_INT      = (1 << PWR_W) - 1;
   localparam logic [PWR_W-1:0]   PHASE_LAST = PWR_W'(P_INT - 1);
   localparam int                 BCW        = (BELL_CYC > 1) ? $clog2(BELL_CYC) : 1;
   localparam logic [BCW-1:0]     BELL_LAST  = BCW'(BELL_CYC - 1);
   localparam logic [TIME_W-1:0]  TIME_ONE   = TIME_W'(1);

   logic [4:0]        state_q, state_d;
   logic [TIME_W-1:0] rem_q,   rem_d;
   logic [PWR_W-1:0]  phase_q, phase_d;
   logic [PWR_W-1:0]  power_q, power_d;
   logic [BCW-1:0]    bcnt_q,  bcnt_d;
   logic              start_ok;

   // Start qualified by the child lock when that option is built in.
`ifdef MICROWAVE_CHILD_LOCK_EN
   assign start_ok = start & ~lock;
`else
   assign start_ok = start;
`endif

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= S_CLOSED;
         rem_q   <= '0;
         phase_q <= '0;
         power_q <= '0;
         bcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         phase_q <= phase_d;
         power_q <= power_d;
         bcnt_q  <= bcnt_d;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      phase_d = phase_q;
      power_d = power_q;
      bcnt_d  = bcnt_q;
      case (state_q)
         S_CLOSED: begin
            if (door) begin
               state_d = S_OPEN;
            end else if (start_ok && (time_in != '0)) begin
               state_d = S_COOK;
               rem_d   = time_in;
               power_d = power_in;
               phase_d = '0;
            end
         end
         S_OPEN: begin
            if (!door) state_d = S_CLOSED;
         end
         S_COOK: begin
            // The PWM phase advances on every cycle spent in COOK; it is
            // re-zeroed on every entry, so its value after leaving is moot.
            phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + 1'b1;
            if (cancel) begin
               state_d = door ? S_OPEN : S_CLOSED;
               rem_d   = '0;
            end else if (door) begin
               state_d = S_PAUSE;
            end else if (tick) begin
               if (rem_q <= TIME_ONE) begin
                  // Last tick: hand over to the bell; never wraps below 0.
                  state_d = S_BELL;
                  rem_d   = '0;
                  bcnt_d  = '0;
               end else begin
                  rem_d = rem_q - TIME_ONE;
               end
            end
         end
         S_PAUSE: begin
            if (cancel) begin
               state_d = door ? S_OPEN : S_CLOSED;
               rem_d   = '0;
            end else if (!door && start_ok) begin
               state_d = S_COOK;
               phase_d = '0;
            end
         end
         S_BELL: begin
            if (door) begin
               state_d = S_OPEN;
            end else if (bcnt_q == BELL_LAST) begin
               state_d = S_CLOSED;
            end else begin
               bcnt_d = bcnt_q + 1'b1;
            end
         end
         default: begin
            // Any non-one-hot code collapses to a safe idle state.
            state_d = S_CLOSED;
            rem_d   = '0;
         end
      endcase
   end

   // ---------------- output decode ----------------
   always_comb begin
      // The door term bypasses the state register so opening the door cuts
      // the magnetron in the same cycle.
      heat      = state_q[I_COOK] & ~door & (phase_q < power_q);
      light     = state_q[I_OPEN] | state_q[I_PAUSE] | state_q[I_COOK];
      bell      = state_q[I_BELL];
      busy      = state_q[I_COOK] | state_q[I_PAUSE];
      remaining = rem_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_microwave_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_microwave_ctrl
//  Description : Self-checking bench for microwave_ctrl. A behavioural oven
//                model predicts every cycle's outputs into a queue; a monitor
//                pops and compares them against the DUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_microwave_ctrl;

   localparam int P = 7;
   localparam int BELL_CYC = 4;
`ifdef MICROWAVE_CHILD_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   localparam int M_CLOSED = 0;
   localparam int M_OPEN   = 1;
   localparam int M_COOK   = 2;
   localparam int M_PAUSE  = 3;
   localparam int M_BELL   = 4;

   typedef struct packed {
      logic       heat;
      logic       light;
      logic       bell;
      logic [7:0] rem;
      logic       busy;
   } exp_t;

   logic       clk = 1'b0;
   logic       nrst = 1'b0;
   logic       door = 1'b0, start = 1'b0, cancel = 1'b0, tick = 1'b0;
   logic [7:0] time_in = '0;
   logic [2:0] power_in = '0;
`ifdef MICROWAVE_CHILD_LOCK_EN
   logic       lock = 1'b0;
`endif
   logic       heat, light, bell, busy;
   logic [7:0] remaining;

   exp_t expq[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // behavioural model state
   int m_mode = M_CLOSED;
   int m_rem = 0, m_pwr = 0, m_cyc = 0, m_bell_left = 0;

   microwave_ctrl #(.TIME_W(8), .PWR_W(3), .BELL_CYC(BELL_CYC)) dut (
      .clk(clk), .nrst(nrst), .door(door), .start(start), .cancel(cancel),
      .tick(tick), .time_in(time_in), .power_in(power_in),
`ifdef MICROWAVE_CHILD_LOCK_EN
      .lock(lock),
`endif
      .heat(heat), .light(light), .bell(bell), .remaining(remaining),
      .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s at %0t: actual %0h required %0h", name, $time, act, req);
      end
   endtask

   // Monitor: the DUT presents a fresh set of outputs every cycle.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            chk("heat",      {7'd0, heat},  {7'd0, e.heat});
            chk("light",     {7'd0, light}, {7'd0, e.light});
            chk("bell",      {7'd0, bell},  {7'd0, e.bell});
            chk("remaining", remaining,     e.rem);
            chk("busy",      {7'd0, busy},  {7'd0, e.busy});
         end
      end
   end

   // Reset pulse: outputs must clear without waiting for a clock edge.
   task automatic rst_pulse();
      exp_t e;
      @(negedge clk);
      nrst = 1'b0; door = 1'b0; start = 1'b0; cancel = 1'b0; tick = 1'b0;
      m_mode = M_CLOSED; m_rem = 0; m_pwr = 0; m_cyc = 0; m_bell_left = 0;
      e = '0;
      expq.push_back(e);
   endtask

   // One clock cycle of stimulus plus the model's prediction for it.
   task automatic cyc(input logic d, input logic s, input logic c, input logic t,
                      input logic [7:0] ti, input logic [2:0] pi, input logic lk);
      exp_t e;
      logic s_ok;
      @(negedge clk);
      nrst = 1'b1; door = d; start = s; cancel = c; tick = t;
      time_in = ti; power_in = pi;
`ifdef MICROWAVE_CHILD_LOCK_EN
      lock = lk;
`endif
      e.heat  = (m_mode == M_COOK) && !d && ((m_cyc % P) < m_pwr);
      e.light = (m_mode == M_OPEN) || (m_mode == M_PAUSE) || (m_mode == M_COOK);
      e.bell  = (m_mode == M_BELL);
      e.busy  = (m_mode == M_COOK) || (m_mode == M_PAUSE);
      e.rem   = 8'(m_rem);
      expq.push_back(e);

      s_ok = s && !(lk && LOCK_EN);
      case (m_mode)
         M_CLOSED: begin
            if (d) m_mode = M_OPEN;
            else if (s_ok && ti != 0) begin
               m_mode = M_COOK; m_rem = int'(ti); m_pwr = int'(pi); m_cyc = 0;
            end
         end
         M_OPEN: if (!d) m_mode = M_CLOSED;
         M_COOK: begin
            m_cyc++;
            if (c) begin
               m_mode = d ? M_OPEN : M_CLOSED; m_rem = 0;
            end else if (d) begin
               m_mode = M_PAUSE;
            end else if (t) begin
               m_rem--;
               if (m_rem == 0) begin
                  m_mode = M_BELL; m_bell_left = BELL_CYC;
               end
            end
         end
         M_PAUSE: begin
            if (c) begin
               m_mode = d ? M_OPEN : M_CLOSED; m_rem = 0;
            end else if (!d && s_ok) begin
               m_mode = M_COOK; m_cyc = 0;
            end
         end
         default: begin // bell
            if (d) m_mode = M_OPEN;
            else begin
               m_bell_left--;
               if (m_bell_left == 0) m_mode = M_CLOSED;
            end
         end
      endcase
   endtask

   task automatic idle(input int n, input int tick_every);
      for (int i = 0; i < n; i++)
         cyc(1'b0, 1'b0, 1'b0, (tick_every > 0) && (i % tick_every == tick_every - 1),
             8'd0, 3'd0, 1'b0);
   endtask

   initial begin
      rst_pulse();
      idle(2, 0);

      // full-power cook of 3 ticks, bell, back to idle
      cyc(0, 1, 0, 0, 8'd3, 3'd7, 0);
      idle(16, 3);

      // power 2 modulation pattern, then cancel
      cyc(0, 1, 0, 0, 8'd20, 3'd2, 0);
      idle(15, 0);
      cyc(0, 0, 1, 0, 8'd0, 3'd0, 0);

      // pause by door, closing alone does not resume, start resumes
      cyc(0, 1, 0, 0, 8'd5, 3'd4, 0);
      idle(3, 0);
      cyc(1, 0, 0, 1, 8'd0, 3'd0, 0);
      cyc(1, 1, 0, 1, 8'd0, 3'd0, 0);
      idle(4, 2);
      cyc(0, 1, 0, 0, 8'd0, 3'd0, 0);
      idle(20, 3);

      // cancel and door together; start with zero time ignored
      cyc(0, 1, 0, 0, 8'd6, 3'd3, 0);
      idle(2, 0);
      cyc(1, 0, 1, 0, 8'd0, 3'd0, 0);
      cyc(1, 1, 0, 0, 8'd4, 3'd0, 0);
      cyc(0, 0, 0, 0, 8'd0, 3'd0, 0);
      cyc(0, 1, 0, 0, 8'd0, 3'd5, 0);
      idle(2, 0);

      // reset mid-cook, no resume after release
      cyc(0, 1, 0, 0, 8'd9, 3'd7, 0);
      idle(3, 0);
      rst_pulse();
      idle(3, 1);

      // door during bell
      cyc(0, 1, 0, 0, 8'd1, 3'd1, 0);
      cyc(0, 0, 0, 1, 8'd0, 3'd0, 0);
      cyc(0, 0, 0, 0, 8'd0, 3'd0, 0);
      cyc(1, 0, 0, 0, 8'd0, 3'd0, 0);
      cyc(1, 0, 0, 0, 8'd0, 3'd0, 0);
      idle(2, 0);

`ifdef MICROWAVE_CHILD_LOCK_EN
      cyc(0, 1, 0, 0, 8'd5, 3'd3, 1);
      idle(2, 0);
      cyc(0, 1, 0, 0, 8'd5, 3'd3, 0);
      cyc(1, 0, 0, 0, 8'd0, 3'd0, 1);
      cyc(0, 1, 0, 0, 8'd0, 3'd0, 1);
      cyc(0, 0, 1, 0, 8'd0, 3'd0, 1);
      idle(2, 0);
`endif

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 599) == 0) begin
            rst_pulse();
         end else begin
            logic [7:0] ti;
            ti = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 6));
            cyc(($urandom_range(0, 11) == 0), ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0),
                ti, 3'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0));
         end
      end

      repeat (3) @(negedge clk);
      n_checks++;
      if (expq.size() != 0) begin
         n_fail++;
         $display("FAIL drain: actual %0d pending, required 0", expq.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/microwave_ctrl.md
MICROWAVE_CTRL -- requirements
Module: microwave_ctrl

Interface
REQ-001 SHALL have parameter TIME_W, default 8, width of cook-time counter in ticks.
REQ-002 SHALL have parameter PWR_W, default 3, width of power level; PWM period P = 2^PWR_W-1 clk cycles.
REQ-003 SHALL have parameter BELL_CYC, default 4, bell duration in clk cycles (>=1).
REQ-004 clk  input  1  clock, all state on rising edge.
REQ-005 nrst  input  1  reset, asynchronous, active-low.
REQ-006 door  input  1  1 = door open.
REQ-007 start  input  1  start/resume request, sampled each cycle.
REQ-008 cancel  input  1  abort current cook.
REQ-009 tick  input  1  one-cycle time-base strobe (e.g. 1 s).
REQ-010 time_in  input  TIME_W  cook time in ticks, latched on start from CLOSED.
REQ-011 power_in  input  PWR_W  power level 0..P, latched on start from CLOSED.
REQ-012 heat  output  1  magnetron enable.
REQ-013 light  output  1  cavity lamp.
REQ-014 bell  output  1  end-of-cook signal.
REQ-015 remaining  output  TIME_W  ticks left.
REQ-016 busy  output  1  cook in progress or paused.

Function
REQ-017 SHALL implement one-hot FSM, states CLOSED, OPEN, COOK, PAUSE, BELL; exactly one active at all times.
REQ-018 CLOSED: door -> OPEN; else start && time_in!=0 -> COOK, remaining<=time_in, power latched, phase<=0; start with time_in==0 ignored.
REQ-019 OPEN: !door -> CLOSED; start, cancel ignored.
REQ-020 COOK priority cancel > door > tick: cancel -> (door ? OPEN : CLOSED), remaining<=0; door -> PAUSE, remaining held; tick && remaining==1 -> BELL, remaining<=0; tick -> remaining-1.
REQ-021 PAUSE: cancel -> (door ? OPEN : CLOSED), remaining<=0; !door && start -> COOK, phase<=0; else stay (closing door alone SHALL NOT resume); tick ignored.
REQ-022 BELL: door -> OPEN; else after BELL_CYC cycles in BELL -> CLOSED; bell counter cleared on entry.
REQ-023 phase counter SHALL count 0..P-1 each cycle in COOK, wrapping to 0; held otherwise.
REQ-024 heat = COOK && !door && (phase < power_latched), door term combinational (zero-cycle cut-off); power 0 -> never, power P -> always.
REQ-025 light = OPEN|PAUSE|COOK; bell = BELL; busy = COOK|PAUSE; all registered-state decodes.
REQ-026 remaining SHALL never underflow; reaches 0 only via BELL entry, cancel or reset.

Reset
REQ-027 nrst low SHALL immediately force CLOSED, remaining=0, phase=0, bell counter=0, power_latched=0; outputs heat=0, light=0, bell=0, busy=0.
REQ-028 reset mid-cook SHALL discard remaining time; no resume after release.

Configuration
REQ-029 macro MICROWAVE_CHILD_LOCK_EN defined: extra input lock (1 bit); while lock=1, start SHALL be ignored in CLOSED and PAUSE, cancel still honoured.
REQ-030 macro undefined: no lock port, behaviour per REQ-017..026.

Verification
REQ-031 TIME_W=8, PWR_W=3: time_in=3, power_in=7, start; 3 ticks -> heat=1 continuously in COOK, remaining 3,2,1, then bell=1 for 4 cycles, then CLOSED.
REQ-032 power_in=2, cook: heat pattern 1,1,0,0,0,0,0 repeating over 7 cycles.
REQ-033 door=1 mid-cook with remaining=5 -> heat=0 same cycle, PAUSE, remaining=5; door=0 -> stays PAUSE; start -> COOK, countdown resumes from 5.
REQ-034 cancel and door same cycle in COOK -> OPEN, remaining=0, busy=0; start with time_in=0 in CLOSED -> no transition.
REQ-035 nrst low during COOK (remaining=9) -> asynchronous CLOSED, all outputs 0; door=1 during BELL -> OPEN, bell=0, light=1.
REQ-036 MICROWAVE_CHILD_LOCK_EN: lock=1, start, time_in=5 -> stays CLOSED; lock=0, start -> COOK.
